zkbdmus_loader: RTL and testbench

- Command sequencer between the slave-SPI byte receiver and the keyboard/mouse/joystick latch block.
- Parses framed byte streams from the AVR and assembles the 40-bit key matrix.
- Drives the single-cycle load strobes (kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb) and their data buses.
- Guarantees the latch block never sees a partial keyboard update or a strobe from a corrupted or aborted frame.

---
 rtl/zkbdmus_loader.sv | 194 +++++++++++++++++++
 tb/tb_zkbdmus_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zkbdmus_loader.sv
// Frame parser between the SPI byte receiver and the keyboard/mouse/joystick latches.
// Latency: load strobes and data appear 1 cycle after the completing byte; no backpressure, bytes outside a frame are dropped.
module zkbdmus_loader #(
  parameter int          TIMEOUT = 1024,
  parameter logic [7:0]  KBD_CMD = 8'h10,
  parameter logic [7:0]  MUS_CMD = 8'h20
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        sel,
  input  logic        in_stb,
  input  logic [7:0]  in_data,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb,
  output logic        kj_stb,
  output logic [7:0]  abort_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, KBD, SINGLE, DONE, SKIP} state_t;
  typedef enum logic [1:0] {TGT_X, TGT_Y, TGT_BTN, TGT_KJ} target_t;

  state_t          state, state_nxt;
  target_t         target, target_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [TW-1:0]   tmo;
  logic [3:0][7:0] shadow;
  logic            sel_q;

  logic            accept;
  logic            tmo_clr;
  logic            tmo_inc;
  logic            tmo_expired;
  logic            shadow_wr;
  logic            kbd_load;
  logic            mus_load;
  logic            abort;
  logic [7:0]      mus_off;

  assign accept      = sel & in_stb;
  assign tmo_expired = (tmo == TW'(TIMEOUT - 1));
  assign mus_off     = in_data - MUS_CMD;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    idx_nxt    = idx;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    shadow_wr  = 1'b0;
    kbd_load   = 1'b0;
    mus_load   = 1'b0;
    abort      = 1'b0;

    case (state)
      // Only a fresh sel rise opens a frame, so a frame cut by reset is not resumed.
      IDLE: begin
        if (sel && !sel_q) begin
          state_nxt = CMD;
          tmo_clr   = 1'b1;
        end
      end

      CMD: begin
        if (!sel) begin
          state_nxt = IDLE;
        end else if (accept) begin
          tmo_clr = 1'b1;
          if (in_data == KBD_CMD) begin
            state_nxt = KBD;
            idx_nxt   = 3'd0;
          end else if (mus_off < 8'd4) begin
            state_nxt  = SINGLE;
            target_nxt = target_t'(mus_off[1:0]);
          end else begin
            state_nxt = SKIP;
            abort     = 1'b1;
          end
        end
      end

      KBD: begin
        if (!sel) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (accept) begin
          tmo_clr = 1'b1;
          if (idx == 3'd4) begin
            kbd_load  = 1'b1;
            state_nxt = DONE;
          end else begin
            shadow_wr = 1'b1;
            idx_nxt   = idx + 3'd1;
          end
        end else if (tmo_expired) begin
          state_nxt = SKIP;
          abort     = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      SINGLE: begin
        if (!sel) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (accept) begin
          tmo_clr   = 1'b1;
          mus_load  = 1'b1;
          state_nxt = DONE;
        end else if (tmo_expired) begin
          state_nxt = SKIP;
          abort     = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      DONE, SKIP: begin
        if (!sel) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      target     <= TGT_X;
      idx        <= 3'd0;
      tmo        <= '0;
      shadow     <= '0;
      sel_q      <= 1'b1;
      kbd_out    <= 40'h0;
      kbd_stb    <= 1'b0;
      mus_out    <= 8'h00;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
      abort_cnt  <= 8'h00;
    end else begin
      target <= target_nxt;
      idx    <= idx_nxt;
      sel_q  <= sel;

      if (tmo_clr) begin
        tmo <= '0;
      end else if (tmo_inc) begin
        tmo <= tmo + TW'(1);
      end

      // Partial matrix never leaves the shadow; an aborted frame wipes it.
      if (abort) begin
        shadow <= '0;
      end else if (shadow_wr) begin
        shadow[idx[1:0]] <= in_data;
      end

      kbd_stb <= kbd_load;
      if (kbd_load) begin
        kbd_out <= {in_data, shadow};
      end

      mus_xstb   <= mus_load && (target == TGT_X);
      mus_ystb   <= mus_load && (target == TGT_Y);
      mus_btnstb <= mus_load && (target == TGT_BTN);
      kj_stb     <= mus_load && (target == TGT_KJ);
      if (mus_load) begin
        mus_out <= in_data;
      end

      if (abort && (abort_cnt != 8'hFF)) begin
        abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_zkbdmus_loader.sv
// Randomized and directed frames against a frame-level model of the loader.
module tb_zkbdmus_loader;
  localparam int TIMEOUT = 1024;

  logic        fclk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_stb;
  logic [7:0]  in_data;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb;
  logic        mus_ystb;
  logic        mus_btnstb;
  logic        kj_stb;
  logic [7:0]  abort_cnt;

  zkbdmus_loader dut (
    .fclk      (fclk),
    .rst       (rst),
    .sel       (sel),
    .in_stb    (in_stb),
    .in_data   (in_data),
    .kbd_out   (kbd_out),
    .kbd_stb   (kbd_stb),
    .mus_out   (mus_out),
    .mus_xstb  (mus_xstb),
    .mus_ystb  (mus_ystb),
    .mus_btnstb(mus_btnstb),
    .kj_stb    (kj_stb),
    .abort_cnt (abort_cnt)
  );

  always #5 fclk = ~fclk;

  logic [4:0] stb_vec;
  assign stb_vec = {kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb};

  int n_chk = 0;
  int n_err = 0;

  // Reference state: what the latch block should currently hold
  logic [39:0] m_kbd;
  logic [7:0]  m_mus;
  logic [7:0]  m_abort;
  logic [7:0]  bq[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_val("no_stb_idle", stb_vec, 5'b0);
    end
  endtask

  task automatic bump_abort();
    if (m_abort != 8'hFF) m_abort = m_abort + 8'd1;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_kbd"}, kbd_out, m_kbd);
    check_val({tag, "_mus"}, mus_out, m_mus);
    check_val({tag, "_abort"}, abort_cnt, m_abort);
  endtask

  // Plays bq as one frame. stall_at/stall_len inserts a long gap before one byte;
  // stb_on_fall strobes a byte in the same cycle sel drops.
  task automatic run_frame(input int stall_at, input int stall_len, input int end_gap,
                           input bit stb_on_fall);
    int          need;
    int          got_n;
    int          gap;
    bit          pending;
    logic [39:0] sh;
    logic [4:0]  exp;
    need    = 0;
    got_n   = 0;
    pending = 1'b0;
    sh      = '0;

    // Rise cycle: a byte here must be ignored
    sel     = 1'b1;
    in_stb  = ($urandom_range(0, 2) == 0);
    in_data = 8'h10;
    tick();
    in_stb  = 1'b0;
    check_val("no_stb_rise", stb_vec, 5'b0);

    foreach (bq[i]) begin
      gap = (i == stall_at) ? stall_len : int'($urandom_range(0, 2));
      idle_cycles(gap);
      exp = 5'b0;
      if (i == 0) begin
        if (bq[0] == 8'h10) begin
          pending = 1'b1;
          need    = 5;
        end else if (bq[0] >= 8'h20 && bq[0] <= 8'h23) begin
          pending = 1'b1;
          need    = 1;
        end else begin
          bump_abort();
        end
      end else if (pending) begin
        if (gap >= TIMEOUT) begin
          pending = 1'b0;
          bump_abort();
        end else begin
          sh[got_n*8 +: 8] = bq[i];
          got_n++;
          if (got_n == need) begin
            pending = 1'b0;
            if (need == 5) begin
              m_kbd = sh;
              exp   = 5'b10000;
            end else begin
              m_mus = bq[i];
              exp   = 5'b01000 >> (bq[0] - 8'h20);
            end
          end
        end
      end
      in_stb  = 1'b1;
      in_data = bq[i];
      tick();
      in_stb  = 1'b0;
      in_data = 8'($urandom);
      check_val("stb_after_byte", stb_vec, exp);
      if (exp[4]) check_val("kbd_on_stb", kbd_out, m_kbd);
      if (exp[3:0] != 4'b0) check_val("mus_on_stb", mus_out, m_mus);
    end

    idle_cycles(end_gap);
    sel     = 1'b0;
    in_stb  = stb_on_fall;
    in_data = 8'h5A;
    tick();
    in_stb  = 1'b0;
    check_val("no_stb_fall", stb_vec, 5'b0);
    if (pending) bump_abort();
    check_outputs("frame_end");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r;
    int  n;
    logic [7:0] cmd;

    rst     = 1'b1;
    sel     = 1'b0;
    in_stb  = 1'b0;
    in_data = 8'h00;
    m_kbd   = '0;
    m_mus   = '0;
    m_abort = '0;
    tick();
    tick();
    check_outputs("reset");
    check_val("reset_stb", stb_vec, 5'b0);
    rst = 1'b0;
    idle_cycles(2);

    // Keyboard load with a trailing 7th byte
    bq = '{8'h10, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h33};
    run_frame(-1, 0, 1, 1'b0);
    check_val("kbd_plan", kbd_out, 40'h10_08_04_02_01);

    // Mouse Y then joystick
    bq = '{8'h21, 8'h7F};
    run_frame(-1, 0, 0, 1'b0);
    check_val("mus_y_plan", mus_out, 8'h7F);
    bq = '{8'h23, 8'h1F};
    run_frame(-1, 0, 0, 1'b0);
    check_val("kj_plan", mus_out, 8'h1F);

    // Keyboard frame cut after 3 data bytes
    bq = '{8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_frame(-1, 0, 2, 1'b0);
    check_val("cut_abort", abort_cnt, 8'd1);
    check_val("cut_kbd_held", kbd_out, 40'h10_08_04_02_01);

    // Invalid command, then a valid button frame
    bq = '{8'h55, 8'h22, 8'hAA};
    run_frame(-1, 0, 0, 1'b0);
    check_val("bad_cmd_abort", abort_cnt, 8'd2);
    bq = '{8'h22, 8'hAA};
    run_frame(-1, 0, 0, 1'b0);
    check_val("btn_plan", mus_out, 8'hAA);

    // Keyboard stall past the timeout after the 2nd data byte
    bq = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(3, TIMEOUT + 8, 0, 1'b0);
    check_val("tmo_abort", abort_cnt, 8'd3);
    // Stall comfortably under the timeout still completes
    bq = '{8'h10, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    run_frame(4, TIMEOUT - 8, 0, 1'b0);
    // Single-byte timeout
    bq = '{8'h20, 8'h77};
    run_frame(1, TIMEOUT + 8, 0, 1'b0);
    // 5th byte coincident with sel fall is dropped
    bq = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(-1, 0, 0, 1'b1);

    for (int f = 0; f < 150; f++) begin
      n = $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h10;
      else if (r < 8) cmd = 8'h20 + 8'($urandom_range(0, 3));
      else cmd = 8'($urandom);
      bq.delete();
      if (n > 0) bq.push_back(cmd);
      for (int k = 1; k < n; k++) bq.push_back(8'($urandom));
      run_frame(-1, 0, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Saturate the abort counter
    for (int f = 0; f < 300; f++) begin
      bq = '{8'h80 | 8'($urandom)};
      run_frame(-1, 0, 0, 1'b0);
    end
    check_val("abort_sat", abort_cnt, 8'hFF);

    // Reset in the middle of a keyboard frame
    sel = 1'b1;
    tick();
    bq = '{8'h10, 8'h01, 8'h02};
    foreach (bq[i]) begin
      in_stb  = 1'b1;
      in_data = bq[i];
      tick();
      in_stb  = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_kbd   = '0;
    m_mus   = '0;
    m_abort = '0;
    check_outputs("mid_reset");
    check_val("mid_reset_stb", stb_vec, 5'b0);
    // sel still high: no command until sel toggles
    bq = '{8'h21, 8'h55};
    foreach (bq[i]) begin
      in_stb  = 1'b1;
      in_data = bq[i];
      tick();
      in_stb  = 1'b0;
      check_val("post_reset_ignored", stb_vec, 5'b0);
    end
    sel = 1'b0;
    tick();
    check_outputs("post_reset_idle");
    bq = '{8'h20, 8'h66};
    run_frame(-1, 0, 0, 1'b0);
    check_val("post_reset_x", mus_out, 8'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
